// File: rtl/avg_pooling_layer.sv
// avg_pooling_layer
// 2x2, stride-2 average pooling over square feature maps held in memory.
// Reads each window's four elements through a request/valid handshake,
// writes one floor-averaged word per window, then holds done until enable
// deasserts.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   enable                  start (while idle) / hold; low aborts the job
//   mapsNumber, mapSize     number of maps and map side N (latched at start)
//   inAddress, outAddress   base addresses of input maps / pooled output
//   readEnable, readAddr    read request, address stable while requested
//   readData, readValid     read response, valid for one cycle
//   writeEnable, writeAddr  one-cycle write strobe and its address
//   writeOut                pooled value written with writeEnable
//   done                    job complete, held until enable drops
module avg_pooling_layer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [15:0]                  mapsNumber,
    input  logic [15:0]                  mapSize,
    input  logic [ADDR_WIDTH-1:0]        inAddress,
    input  logic [ADDR_WIDTH-1:0]        outAddress,
    output logic                         readEnable,
    output logic [ADDR_WIDTH-1:0]        readAddr,
    input  logic signed [DATA_WIDTH-1:0] readData,
    input  logic                         readValid,
    output logic                         writeEnable,
    output logic [ADDR_WIDTH-1:0]        writeAddr,
    output logic signed [DATA_WIDTH-1:0] writeOut,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, REQ, WR, DONE} state_t;

    state_t                       state;
    logic [15:0]                  mapsReg, sizeReg;
    logic [15:0]                  mapCnt, rowCnt, colCnt;
    logic [1:0]                   elemCnt;
    logic [ADDR_WIDTH-1:0]        winBase;   // address of element (2i, 2j)
    logic [ADDR_WIDTH-1:0]        rowBase;   // address of element (2i, 0)
    logic signed [DATA_WIDTH+1:0] acc;

    logic [15:0]                  outSide;
    logic [ADDR_WIDTH-1:0]        sizeA, nextWin, nextRow;
    logic                         lastCol, lastRow, lastMap;
    logic signed [DATA_WIDTH+1:0] dataExt, sum;

    // Four signed words summed in DATA_WIDTH+2 bits always fit, so the
    // arithmetic shift result is always representable: no saturation needed.
    function automatic logic signed [DATA_WIDTH-1:0] avgOf4(input logic signed [DATA_WIDTH+1:0] s);
        logic signed [DATA_WIDTH+1:0] q;
        q = s >>> 2;
        return q[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        outSide = {1'b0, sizeReg[15:1]};
        sizeA   = ADDR_WIDTH'(sizeReg);
        lastCol = (colCnt == outSide - 16'd1);
        lastRow = (rowCnt == outSide - 16'd1);
        lastMap = (mapCnt == mapsReg - 16'd1);
        dataExt = {{2{readData[DATA_WIDTH-1]}}, readData};
        sum     = acc + dataExt;
        nextRow = rowBase;
        nextWin = winBase + ADDR_WIDTH'(2);
        if (lastCol && !lastRow) begin
            nextRow = rowBase + (sizeA << 1);
            nextWin = nextRow;
        end else if (lastCol) begin
            // Next map starts N*N after this map; from the last pooled row
            // that is two rows on, plus the skipped odd row when N is odd.
            nextRow = rowBase + (sizeA << 1) + (sizeReg[0] ? sizeA : '0);
            nextWin = nextRow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            readEnable  <= 1'b0;
            readAddr    <= '0;
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeOut    <= '0;
            done        <= 1'b0;
            mapsReg     <= '0;
            sizeReg     <= '0;
            mapCnt      <= '0;
            rowCnt      <= '0;
            colCnt      <= '0;
            elemCnt     <= '0;
            winBase     <= '0;
            rowBase     <= '0;
            acc         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (mapsNumber == 16'd0 || mapSize < 16'd2) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= REQ;
                            readEnable <= 1'b1;
                            readAddr   <= inAddress;
                            winBase    <= inAddress;
                            rowBase    <= inAddress;
                            writeAddr  <= outAddress;
                            mapsReg    <= mapsNumber;
                            sizeReg    <= mapSize;
                            mapCnt     <= '0;
                            rowCnt     <= '0;
                            colCnt     <= '0;
                            elemCnt    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (!enable) begin
                        state      <= IDLE;
                        readEnable <= 1'b0;
                    end else if (readValid) begin
                        elemCnt <= elemCnt + 2'd1;
                        acc     <= (elemCnt == 2'd0) ? dataExt : sum;
                        case (elemCnt)
                            2'd0:    readAddr <= winBase + ADDR_WIDTH'(1);
                            2'd1:    readAddr <= winBase + sizeA;
                            2'd2:    readAddr <= winBase + sizeA + ADDR_WIDTH'(1);
                            default: begin
                                state       <= WR;
                                readEnable  <= 1'b0;
                                writeEnable <= 1'b1;
                                writeOut    <= avgOf4(sum);
                            end
                        endcase
                    end
                end
                WR: begin
                    writeEnable <= 1'b0;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (lastCol && lastRow && lastMap) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= REQ;
                        readEnable <= 1'b1;
                        readAddr   <= nextWin;
                        winBase    <= nextWin;
                        rowBase    <= nextRow;
                        writeAddr  <= writeAddr + ADDR_WIDTH'(1);
                        if (!lastCol) begin
                            colCnt <= colCnt + 16'd1;
                        end else begin
                            colCnt <= '0;
                            if (!lastRow) begin
                                rowCnt <= rowCnt + 16'd1;
                            end else begin
                                rowCnt <= '0;
                                mapCnt <= mapCnt + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
